// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        ERR
    } loader_state_t;

    localparam int unsigned LEN_W = 16;

endpackage

// File: rtl/word_packer.sv
// Packs a little-endian byte stream into 32-bit words; word_valid is high
// in the same cycle the fourth byte of a word is presented and accepted.
module word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt_q;
    logic [23:0] sr_q;

    // Bytes shift in from the top so the first byte lands in the low lane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sr_q  <= '0;
        end else if (byte_en) begin
            cnt_q <= cnt_q + 2'd1;
            sr_q  <= {byte_data, sr_q[23:8]};
        end
    end

    assign word_valid = byte_en && (cnt_q == 2'd3);
    assign word       = {byte_data, sr_q};

endmodule

// File: rtl/instr_loader.sv
// Loads a length-prefixed byte image into instruction memory, one registered
// write per packed word at sequential addresses from 0; busy holds the core off.
module instr_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [LEN_W:0] DEPTH = {{LEN_W{1'b0}}, 1'b1} << ADDR_WIDTH;

    loader_state_t         state_q;
    logic [7:0]            len_lo_q;
    logic [LEN_W-1:0]      remain_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  byte_ready_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;

    logic                  accept;
    logic                  pack_en;
    logic                  word_valid;
    logic [31:0]           word;
    logic [LEN_W-1:0]      len_hdr;

    assign accept  = byte_valid && byte_ready_q;
    assign pack_en = accept && (state_q == DATA);
    assign len_hdr = {byte_data, len_lo_q};

    word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_en    (pack_en),
        .byte_data  (byte_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            len_lo_q     <= '0;
            remain_q     <= '0;
            addr_q       <= '0;
            byte_ready_q <= 1'b0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE, ERR: begin
                    if (start) begin
                        state_q      <= LEN_LO;
                        addr_q       <= '0;
                        byte_ready_q <= 1'b1;
                        busy_q       <= 1'b1;
                        error_q      <= 1'b0;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        len_lo_q <= byte_data;
                        state_q  <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        remain_q <= len_hdr;
                        if (len_hdr == '0) begin
                            state_q      <= IDLE;
                            done_q       <= 1'b1;
                            busy_q       <= 1'b0;
                            byte_ready_q <= 1'b0;
                        end else if ({1'b0, len_hdr} > DEPTH) begin
                            // Ready stays high so the rest of the image drains.
                            state_q <= ERR;
                            error_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (word_valid) begin
                        we_q     <= 1'b1;
                        waddr_q  <= addr_q;
                        wdata_q  <= word;
                        addr_q   <= addr_q + ADDR_WIDTH'(1);
                        remain_q <= remain_q - LEN_W'(1);
                        if (remain_q == LEN_W'(1)) begin
                            state_q      <= IDLE;
                            done_q       <= 1'b1;
                            busy_q       <= 1'b0;
                            byte_ready_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign byte_ready = byte_ready_q;
    assign we         = we_q;
    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: expected writes/done pulses are queued by
// the stimulus and popped by a monitor whenever the DUT shows we or done.
module tb_instr_loader;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = '0;
    logic          byte_ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;
    logic          busy;
    logic          done;
    logic          error;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic          done;
    } exp_t;

    exp_t exp_q[$];

    instr_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle with we or done must match the head of the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (we === 1'b1 || done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {we, done}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("we", we, e.we);
                    check("done", done, e.done);
                    if (e.we) begin
                        check("waddr", waddr, e.addr);
                        check("wdata", wdata, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic push_write(input int addr, input logic [31:0] data, input logic last);
        exp_t e;
        e.we   = 1'b1;
        e.addr = addr[AW-1:0];
        e.data = data;
        e.done = last;
        exp_q.push_back(e);
    endtask

    task automatic push_done_only();
        exp_t e;
        e.we   = 1'b0;
        e.addr = '0;
        e.data = '0;
        e.done = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        for (int i = 0; i < gap; i++) begin
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        waited = 0;
        while (byte_ready !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 20) check("byte_ready_wait", byte_ready, 32'h1);
        byte_valid = 1'b1;
        byte_data  = b;
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic gapped);
        for (int i = 0; i < 4; i++)
            send_byte(w[8*i +: 8], gapped ? int'($urandom_range(1, 3)) : 0);
    endtask

    task automatic start_load(input string name);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({name, "_busy"}, busy, 32'h1);
        check({name, "_ready"}, byte_ready, 32'h1);
    endtask

    task automatic drain(input string name);
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        check({name, "_queue_empty"}, exp_q.size(), 32'h0);
    endtask

    task automatic two_word_load(input string name, input logic gapped);
        push_write(0, 32'hDEADBEEF, 1'b0);
        push_write(1, 32'h12345678, 1'b1);
        start_load(name);
        send_byte(8'h02, gapped ? 1 : 0);
        send_byte(8'h00, gapped ? 2 : 0);
        send_word(32'hDEADBEEF, gapped);
        send_word(32'h12345678, gapped);
        check({name, "_busy_end"}, busy, 32'h0);
        drain(name);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs", {byte_ready, we, busy, done, error}, 32'h0);
        check("rst_waddr", waddr, 32'h0);
        check("rst_wdata", wdata, 32'h0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_ready", byte_ready, 32'h0);
        check("idle_busy", busy, 32'h0);

        two_word_load("b2b", 1'b0);

        // Empty image
        push_done_only();
        start_load("empty");
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check("empty_busy", busy, 32'h0);
        drain("empty");

        // Oversize header: N = 4097
        start_load("over");
        send_byte(8'h01, 0);
        send_byte(8'h10, 0);
        check("over_error", error, 32'h1);
        check("over_busy", busy, 32'h0);
        check("over_ready", byte_ready, 32'h1);
        send_word(32'hBEEF0000, 1'b0);
        check("over_sticky", error, 32'h1);
        start_load("restart");
        check("restart_error", error, 32'h0);
        push_write(0, 32'h11223344, 1'b1);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_word(32'h11223344, 1'b0);
        drain("restart");

        two_word_load("gap", 1'b1);

        // Mid-load reset after 6 data bytes
        push_write(0, 32'hA1B2C3D4, 1'b0);
        start_load("midrst");
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        send_word(32'hA1B2C3D4, 1'b0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {byte_ready, we, busy, done, error}, 32'h0);
        check("midrst_waddr", waddr, 32'h0);
        check("midrst_wdata", wdata, 32'h0);
        check("midrst_queue", exp_q.size(), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        push_write(0, 32'hCAFEF00D, 1'b1);
        start_load("fresh");
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_word(32'hCAFEF00D, 1'b1);
        drain("fresh");

        // N == DEPTH is legal and fills the whole memory
        for (int i = 0; i < (1 << AW); i++)
            push_write(i, 32'hA5000000 ^ (i * 32'h00010003), i == (1 << AW) - 1);
        start_load("full");
        send_byte(8'h00, 0);
        send_byte(8'h10, 0);
        check("full_no_error", error, 32'h0);
        for (int i = 0; i < (1 << AW); i++)
            send_word(32'hA5000000 ^ (i * 32'h00010003), 1'b0);
        check("full_busy_end", busy, 32'h0);
        drain("full");

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
